// File: rtl/priority_grant_arbiter_if.sv
// Request/grant bundle between requesters and the priority_grant_arbiter.
interface priority_grant_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output en, req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input en, req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/priority_grant_arbiter.sv
// Registered 8-way arbiter: fixed-priority or round-robin pick, grant held until
// done, request drop, disable or MAX_HOLD timeout; one idle cycle between grants.
module priority_grant_arbiter #(
  parameter int unsigned RR       = 0,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  priority_grant_arbiter_if.slave   bus
);

  localparam int unsigned N   = 8;
  localparam int unsigned IDW = 3;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0]     last_id_q, last_id_d;

  logic [IDW-1:0]     pick_id;
  logic [IDW-1:0]     base_id;
  logic [IDW-1:0]     cand_id;
  logic               hold_hit;
  logic               early_rel;

  // Search from base-1 down to base (mod 8); nearest-in-order set bit wins.
  always_comb begin
    base_id = (RR != 0) ? last_id_q : '0;
    pick_id = '0;
    cand_id = '0;
    for (int k = N; k >= 1; k--) begin
      cand_id = base_id - IDW'(k);
      if (bus.req[cand_id]) pick_id = cand_id;
    end
  end

  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign early_rel = bus.done || !bus.req[gnt_id_q] || !bus.en;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_id_d   = last_id_q;
    case (state_q)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          state_d     = GRANT;
          gnt_d       = N'(1) << pick_id;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (early_rel || hold_hit) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          last_id_d   = gnt_id_q;
          // Timeout is flagged only when nothing else caused the release.
          timeout_d   = hold_hit && !early_rel;
        end else begin
          hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_id_q   <= last_id_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// Bench: fixed-priority and round-robin arbiters driven in parallel, checked per cycle
// against a grant-lifetime reference model plus directed scenario checks.
module tb_priority_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  priority_grant_arbiter_if ifa ();
  priority_grant_arbiter_if ifb ();

  assign ifa.en = en;  assign ifa.req = req;  assign ifa.done = done;
  assign ifb.en = en;  assign ifb.req = req;  assign ifb.done = done;

  priority_grant_arbiter #(.RR(0), .MAX_HOLD(16), .CNT_W(5)) u_fix (.clk(clk), .rst(rst), .bus(ifa));
  priority_grant_arbiter #(.RR(1), .MAX_HOLD(4),  .CNT_W(3)) u_rr  (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  // Reference: who owns the resource, for how many cycles, and who owned it last.
  typedef struct {
    bit owned;
    int owner;
    int age;
    int prev;
    bit tmo;
  } arb_model_t;

  arb_model_t ma, mb;

  function automatic arb_model_t model_step(arb_model_t m, bit rr, int max_hold);
    arb_model_t n = m;
    n.tmo = 1'b0;
    if (rst) begin
      n.owned = 1'b0; n.owner = 0; n.age = 0; n.prev = 0;
    end else if (!m.owned) begin
      if (en && req != 8'h00) begin
        int start = rr ? m.prev : 0;
        for (int step = 1; step <= 8; step++) begin
          int cand = ((start - step) % 8 + 8) % 8;
          if (req[cand]) begin
            n.owner = cand;
            break;
          end
        end
        n.owned = 1'b1;
        n.age   = 1;
      end
    end else begin
      bit other = done || !req[m.owner] || !en;
      bit limit = (max_hold != 0) && (m.age == max_hold);
      if (other || limit) begin
        n.owned = 1'b0;
        n.prev  = m.owner;
        n.tmo   = limit && !other;
      end else begin
        n.age = m.age + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_model(input string pfx, input arb_model_t m,
                           input logic [7:0] g, input logic [2:0] gid,
                           input logic gv, input logic to);
    chk({pfx, "_gnt"},    32'(g),   m.owned ? 32'(1) << m.owner : 32'h0);
    chk({pfx, "_gnt_id"}, 32'(gid), 32'(m.owner));
    chk({pfx, "_valid"},  32'(gv),  32'(m.owned));
    chk({pfx, "_tmo"},    32'(to),  32'(m.tmo));
  endtask

  // One clock: advance model with the inputs the DUT samples, then compare.
  task automatic cycle();
    ma = model_step(ma, 1'b0, 16);
    mb = model_step(mb, 1'b1, 4);
    @(posedge clk);
    #1;
    cmp_model("fix", ma, ifa.gnt, ifa.gnt_id, ifa.gnt_valid, ifa.timeout);
    cmp_model("rr",  mb, ifb.gnt, ifb.gnt_id, ifb.gnt_valid, ifb.timeout);
  endtask

  initial begin
    ma = '{owned: 1'b0, owner: 0, age: 0, prev: 0, tmo: 1'b0};
    mb = ma;
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    repeat (2) cycle();
    chk("rst_gnt", 32'(ifa.gnt), 32'h0);
    rst = 1'b0;

    // Fixed priority picks index 5, done releases next cycle.
    en = 1'b1; req = 8'b0010_0110;
    cycle();
    chk("t1_gnt", 32'(ifa.gnt), 32'h20);
    chk("t1_id",  32'(ifa.gnt_id), 32'd5);
    done = 1'b1; cycle(); done = 1'b0;
    chk("t1_rel", 32'(ifa.gnt), 32'h0);
    cycle();

    // Round-robin walk with all requests held.
    req = 8'hFF; done = 1'b0;
    cycle(); cycle(); cycle();
    for (int i = 0; i < 18; i++) begin
      done = ifb.gnt_valid; cycle();
    end
    done = 1'b0; req = 8'h00; cycle(); cycle();

    // Single holder runs into MAX_HOLD=16 on the fixed arbiter.
    req = 8'h08; cycle();
    repeat (15) cycle();
    chk("t3_held", 32'(ifa.gnt), 32'h08);
    cycle();
    chk("t3_tmo",  32'(ifa.timeout), 32'd1);
    chk("t3_rel",  32'(ifa.gnt), 32'h0);
    cycle();
    chk("t3_regnt", 32'(ifa.gnt_id), 32'd3);
    repeat (15) cycle();
    done = 1'b1; cycle(); done = 1'b0;
    chk("t4_tmo", 32'(ifa.timeout), 32'd0);
    chk("t4_rel", 32'(ifa.gnt), 32'h0);

    // Disable mid-grant, then hold off a request until re-enabled.
    cycle();
    en = 1'b0; cycle();
    chk("t5_off", 32'(ifa.gnt), 32'h0);
    req = 8'h01; cycle(); cycle();
    chk("t5_blk", 32'(ifa.gnt_valid), 32'd0);
    en = 1'b1; cycle();
    chk("t5_id", 32'(ifa.gnt_id), 32'd0);

    // Reset mid-grant restarts round-robin order at 7.
    req = 8'h00; cycle(); cycle();
    req = 8'h10; cycle();
    chk("t6_id", 32'(ifb.gnt_id), 32'd4);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("t6_rst", 32'(ifb.gnt) | 32'(ifb.gnt_id) | 32'(ifb.gnt_valid), 32'h0);
    req = 8'hFF; cycle();
    chk("t6_rr7", 32'(ifb.gnt_id), 32'd7);

    // Randomised traffic with level-held requests.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      en   = ($urandom_range(0, 15) != 0);
      done = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
